// File: rtl/fetdriver_topsw_seq.sv
// Break-before-make sequencer for a segmented top PMOS and bottom NMOS with staged turn-on
// and latched overcurrent fault. Optional leading-edge blanking: define FETDRV_BLANKING_EN.
module fetdriver_topsw_seq #(
  parameter int unsigned NSEG      = 4,
  parameter int unsigned CW        = 8,
  parameter int unsigned DT_CYC    = 8,
  parameter int unsigned RAMP_CYC  = 4,
  parameter int unsigned BLANK_CYC = 6
) (
  input  logic            CLK,
  input  logic            RESETN,
  input  logic            EN,
  input  logic            PWM_IN,
  input  logic            OC_FLT,
  input  logic            FLT_CLR,
  output logic            TOP_GATE_N,
  output logic [NSEG-1:0] SEG_EN,
  output logic            BOT_GATE,
  output logic            FAULT,
  output logic            BUSY
);

  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  if (NSEG == 0 || CW == 0 || CW > 16) begin : g_bad_shape
    $error("fetdriver_topsw_seq: NSEG must be >= 1 and CW in 1..16");
  end
  if (DT_CYC == 0 || DT_CYC > CNT_MAX) begin : g_bad_dt
    $error("fetdriver_topsw_seq: DT_CYC out of range 1..2^CW-1");
  end
  if (RAMP_CYC == 0 || RAMP_CYC > CNT_MAX) begin : g_bad_ramp
    $error("fetdriver_topsw_seq: RAMP_CYC out of range 1..2^CW-1");
  end
  if (BLANK_CYC > CNT_MAX) begin : g_bad_blank
    $error("fetdriver_topsw_seq: BLANK_CYC exceeds counter range");
  end

  localparam logic [CW-1:0] DT_LAST   = CW'(DT_CYC - 1);
  localparam logic [CW-1:0] RAMP_LAST = CW'(RAMP_CYC - 1);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_DT_TOP = 3'd1,
    ST_RAMP   = 3'd2,
    ST_TOP_ON = 3'd3,
    ST_DT_BOT = 3'd4,
    ST_BOT_ON = 3'd5,
    ST_FLT    = 3'd6
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic [CW-1:0]   cnt_inc;
  logic [NSEG-1:0] seg_nx;
  logic [NSEG-1:0] seg_sh;
  logic            oc_meta;
  logic            oc_s;
  logic            blank_c;

  // Two-flop synchroniser for the asynchronous overcurrent flag
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      oc_meta <= 1'b0;
      oc_s    <= 1'b0;
    end else begin
      oc_meta <= OC_FLT;
      oc_s    <= oc_meta;
    end
  end

`ifdef FETDRV_BLANKING_EN
  logic [CW-1:0] blank_cnt;

  // Blanking window starts on the edge that enters RAMP
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      blank_cnt <= '0;
    end else if (state_nx == ST_RAMP && state != ST_RAMP) begin
      blank_cnt <= CW'(BLANK_CYC);
    end else if (blank_cnt != '0) begin
      blank_cnt <= blank_cnt - CW'(1);
    end
  end

  assign blank_c = (state == ST_RAMP) && (blank_cnt != '0);
`else
  assign blank_c = 1'b0;
`endif

  assign cnt_inc = (&cnt) ? cnt : cnt + CW'(1);
  assign seg_sh  = (SEG_EN << 1) | NSEG'(1);

  // Next-state, counter and segment pattern
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    seg_nx   = '0;
    unique case (state)
      ST_OFF: begin
        if (EN) state_nx = PWM_IN ? ST_DT_TOP : ST_DT_BOT;
      end
      ST_DT_TOP: begin
        if (!PWM_IN) begin
          state_nx = ST_DT_BOT;
        end else if (cnt == DT_LAST) begin
          seg_nx   = NSEG'(1);
          state_nx = (&seg_nx) ? ST_TOP_ON : ST_RAMP;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      ST_DT_BOT: begin
        if (PWM_IN) begin
          state_nx = ST_DT_TOP;
        end else if (cnt == DT_LAST) begin
          state_nx = ST_BOT_ON;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      ST_RAMP: begin
        if (!PWM_IN) begin
          state_nx = ST_DT_BOT;
        end else if (cnt == RAMP_LAST) begin
          seg_nx = seg_sh;
          if (&seg_sh) state_nx = ST_TOP_ON;
        end else begin
          seg_nx = SEG_EN;
          cnt_nx = cnt_inc;
        end
      end
      ST_TOP_ON: begin
        if (!PWM_IN) state_nx = ST_DT_BOT;
        else         seg_nx   = '1;
      end
      ST_BOT_ON: begin
        if (PWM_IN) state_nx = ST_DT_TOP;
      end
      ST_FLT: begin
        if (FLT_CLR && !oc_s && !PWM_IN) state_nx = ST_OFF;
      end
      default: state_nx = ST_OFF;
    endcase

    if (state != ST_FLT && !EN) begin
      state_nx = ST_OFF;
      cnt_nx   = '0;
      seg_nx   = '0;
    end

    // Overcurrent wins over enable and PWM
    if (state != ST_OFF && oc_s && !blank_c) begin
      state_nx = ST_FLT;
      cnt_nx   = '0;
      seg_nx   = '0;
    end
  end

  // State, counter and outputs all registered from the next-state decision
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= ST_OFF;
      cnt        <= '0;
      TOP_GATE_N <= 1'b1;
      SEG_EN     <= '0;
      BOT_GATE   <= 1'b0;
      FAULT      <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      TOP_GATE_N <= !(state_nx == ST_RAMP || state_nx == ST_TOP_ON);
      SEG_EN     <= seg_nx;
      BOT_GATE   <= (state_nx == ST_BOT_ON);
      FAULT      <= (state_nx == ST_FLT);
      BUSY       <= (state_nx == ST_DT_TOP || state_nx == ST_DT_BOT);
    end
  end

endmodule

// File: tb/tb_fetdriver_topsw_seq.sv
// Scoreboard bench for fetdriver_topsw_seq: directed per-cycle vectors queued with
// hand-computed outputs, checked by an independent monitor on the falling edge.
module tb_fetdriver_topsw_seq;

  // Output vector: {TOP_GATE_N, SEG_EN[3:0], BOT_GATE, FAULT, BUSY}
  localparam logic [7:0] E_OFF = 8'b1_0000_0_0_0;
  localparam logic [7:0] E_DT  = 8'b1_0000_0_0_1;
  localparam logic [7:0] E_R1  = 8'b0_0001_0_0_0;
  localparam logic [7:0] E_R2  = 8'b0_0011_0_0_0;
  localparam logic [7:0] E_R3  = 8'b0_0111_0_0_0;
  localparam logic [7:0] E_TON = 8'b0_1111_0_0_0;
  localparam logic [7:0] E_BON = 8'b1_0000_1_0_0;
  localparam logic [7:0] E_FLT = 8'b1_0000_0_1_0;

  typedef struct {
    logic [7:0] v;
    string      nm;
  } exp_t;

  logic       clk;
  logic       RESETN;
  logic       EN;
  logic       PWM_IN;
  logic       OC_FLT;
  logic       FLT_CLR;
  logic       TOP_GATE_N;
  logic [3:0] SEG_EN;
  logic       BOT_GATE;
  logic       FAULT;
  logic       BUSY;

  exp_t       exp_q[$];
  exp_t       cur;
  logic [7:0] act;
  int         n_cmp = 0;
  int         n_bad = 0;
  event       chk_ev;

  fetdriver_topsw_seq dut (
    .CLK       (clk),
    .RESETN    (RESETN),
    .EN        (EN),
    .PWM_IN    (PWM_IN),
    .OC_FLT    (OC_FLT),
    .FLT_CLR   (FLT_CLR),
    .TOP_GATE_N(TOP_GATE_N),
    .SEG_EN    (SEG_EN),
    .BOT_GATE  (BOT_GATE),
    .FAULT     (FAULT),
    .BUSY      (BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge
  task automatic cyc(input logic en, input logic pwm, input logic oc, input logic clr,
                     input logic [7:0] e, input string nm);
    EN      = en;
    PWM_IN  = pwm;
    OC_FLT  = oc;
    FLT_CLR = clr;
    exp_q.push_back('{v: e, nm: nm});
    @(negedge clk);
    #1;
  endtask

  // Queue an expectation and have the monitor check it immediately
  task automatic chk_now(input logic [7:0] e, input string nm);
    exp_q.push_back('{v: e, nm: nm});
    #1;
    ->chk_ev;
    #0;
  endtask

  // Monitor: gate-safety invariants every falling edge, plus scoreboard pop
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      act = {TOP_GATE_N, SEG_EN, BOT_GATE, FAULT, BUSY};
      n_cmp++;
      if ((!TOP_GATE_N && BOT_GATE) || (SEG_EN != 4'b0000 && TOP_GATE_N)) begin
        n_bad++;
        $display("FAIL invariant @%0t: got tgn=%b seg=%b bot=%b, required no overlap and seg=0 when tgn=1",
                 $time, TOP_GATE_N, SEG_EN, BOT_GATE);
      end
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        n_cmp++;
        if (act !== cur.v) begin
          n_bad++;
          $display("FAIL %s @%0t: got %b expected %b (tgn,seg,bot,fault,busy)",
                   cur.nm, $time, act, cur.v);
        end
      end
    end
  end

  initial begin
    RESETN  = 1'b0;
    EN      = 1'b0;
    PWM_IN  = 1'b0;
    OC_FLT  = 1'b0;
    FLT_CLR = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_now(E_OFF, "reset_values");
    RESETN = 1'b1;
    cyc(0, 0, 0, 0, E_OFF, "idle_en0");
    cyc(0, 1, 0, 1, E_OFF, "idle_en0_pwm1");

    // T1: dead time then staged segment ramp to full on
    repeat (8) cyc(1, 1, 0, 0, E_DT,  "t1_dead_time");
    repeat (4) cyc(1, 1, 0, 0, E_R1,  "t1_seg1");
    repeat (4) cyc(1, 1, 0, 0, E_R2,  "t1_seg2");
    repeat (4) cyc(1, 1, 0, 0, E_R3,  "t1_seg3");
    repeat (3) cyc(1, 1, 0, 0, E_TON, "t1_top_on");

    // T2: top off on the same edge, then dead time, then bottom on
    repeat (8) cyc(1, 0, 0, 0, E_DT,  "t2_dead_time");
    repeat (3) cyc(1, 0, 0, 0, E_BON, "t2_bot_on");

    // T3: command flips at dead-time count 5, counter restarts
    repeat (5) cyc(1, 1, 0, 0, E_DT,  "t3_dt_top");
    repeat (8) cyc(1, 0, 0, 0, E_DT,  "t3_dt_restart");
    repeat (2) cyc(1, 0, 0, 0, E_BON, "t3_bot_on");

    // T4: one-cycle overcurrent in TOP_ON, fault clear rules
    repeat (8) cyc(1, 1, 0, 0, E_DT,  "t4_dead_time");
    repeat (4) cyc(1, 1, 0, 0, E_R1,  "t4_seg1");
    repeat (4) cyc(1, 1, 0, 0, E_R2,  "t4_seg2");
    repeat (4) cyc(1, 1, 0, 0, E_R3,  "t4_seg3");
    repeat (2) cyc(1, 1, 0, 0, E_TON, "t4_top_on");
    cyc(1, 1, 0, 1, E_TON, "t4_clr_ignored_in_top_on");
    cyc(1, 1, 1, 0, E_TON, "t4_oc_edge1");
    cyc(1, 1, 0, 0, E_TON, "t4_oc_edge2");
    cyc(1, 1, 0, 0, E_FLT, "t4_oc_edge3_fault");
    cyc(1, 1, 0, 1, E_FLT, "t4_clr_pwm1_ignored");
    cyc(0, 0, 0, 0, E_FLT, "t4_en0_holds_fault");
    cyc(1, 0, 0, 1, E_OFF, "t4_clr_to_off");
    repeat (8) cyc(1, 0, 0, 0, E_DT,  "t4_dt_bot_after_off");
    repeat (2) cyc(1, 0, 0, 0, E_BON, "t4_bot_on");
    cyc(0, 0, 0, 0, E_OFF, "t4_en_removed_bot_on");

    // T5: overcurrent held from RAMP entry faults 3 edges later (no blanking build)
    repeat (8) cyc(1, 1, 0, 0, E_DT,  "t5_dead_time");
    cyc(1, 1, 1, 0, E_R1,  "t5_ramp_entry_oc");
    cyc(1, 1, 1, 0, E_R1,  "t5_oc_edge2");
    cyc(1, 1, 1, 0, E_FLT, "t5_oc_edge3_fault");
    cyc(1, 0, 1, 1, E_FLT, "t5_clr_oc_high");
    cyc(1, 0, 0, 0, E_FLT, "t5_oc_dropped");
    cyc(1, 0, 0, 1, E_FLT, "t5_clr_oc_s_still_high");
    cyc(1, 0, 0, 1, E_OFF, "t5_clr_to_off");
    cyc(0, 0, 0, 0, E_OFF, "t5_idle");

    // T6: asynchronous reset mid-RAMP, then full dead time after release
    repeat (8) cyc(1, 1, 0, 0, E_DT, "t6_dead_time");
    repeat (2) cyc(1, 1, 0, 0, E_R1, "t6_seg1");
    RESETN = 1'b0;
    chk_now(E_OFF, "t6_async_reset");
    cyc(1, 1, 0, 0, E_OFF, "t6_held_in_reset");
    RESETN = 1'b1;
    repeat (8) cyc(1, 1, 0, 0, E_DT, "t6_dt_after_release");
    repeat (4) cyc(1, 1, 0, 0, E_R1, "t6_seg1_after_release");
    cyc(1, 1, 0, 0, E_R2, "t6_seg2_after_release");
    cyc(0, 1, 0, 0, E_OFF, "t6_en_removed_in_ramp");
    cyc(0, 1, 0, 0, E_OFF, "t6_stay_off");

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
